// File: rtl/exception_unit_pkg.sv
// rtl/exception_unit_pkg.sv - exception unit state encoding and cause numbering
package exceptionGroup;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HELD  = 2'd1,
      TAKEN = 2'd2
   } state_e;

   localparam logic [4:0] CAUSE_ILLEGAL  = 5'd0;
   localparam logic [4:0] CAUSE_SYSCALL  = 5'd1;
   localparam logic [4:0] CAUSE_MISALIGN = 5'd2;
   localparam logic [4:0] CAUSE_IRQ_BASE = 5'd16;

endpackage

// File: rtl/exception_unit_priority_encoder16.sv
// rtl/exception_unit_priority_encoder16.sv - 16-bit priority encoder, lowest set bit wins
module priority_encoder16 (
   input  logic [15:0] in,
   output logic        valid,
   output logic [3:0]  index
);

   always_comb begin
      valid = |in;
      index = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (in[i]) index = 4'(i);
      end
   end

endmodule

// File: rtl/exception_unit.sv
// rtl/exception_unit.sv - exception/IRQ collector, prioritiser and ISR vector generator
module exception_unit
   import exceptionGroup::*;
#(
   parameter int IRQ_EDGE     = 1,
   parameter int VECTOR_SHIFT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] exceptionReq,
   input  logic [15:0] irq,
   input  logic        interruptEnable,
   input  logic [15:0] exceptionMask,
   input  logic [31:0] isrBaseAddress,
   input  logic        exceptionAck,
   output logic        exceptionPending,
   output logic [4:0]  cause,
   output logic [31:0] vectorAddress,
   output logic        exceptionTaken
);

   state_e      state;
   logic [4:0]  heldCause;
   logic [15:0] irqPending;
   logic [15:0] extReq;
   logic        int_v, ext_v;
   logic [3:0]  int_idx, ext_idx;
   logic [4:0]  int_cause, winner;

   generate
      if (IRQ_EDGE != 0) begin : g_edge
         logic [15:0] irq_d, pend_q, clr;

         // Only a taken external cause retires its sticky bit; a fresh edge wins over it.
         always_comb begin
            clr = 16'h0;
            if (state == HELD && exceptionAck && heldCause[4])
               clr = 16'h1 << heldCause[3:0];
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               irq_d  <= 16'h0;
               pend_q <= 16'h0;
            end else begin
               irq_d  <= irq;
               pend_q <= (pend_q & ~clr) | (irq & ~irq_d);
            end
         end

         assign irqPending = pend_q;
      end else begin : g_level
         assign irqPending = irq;
      end
   endgenerate

   assign extReq = irqPending & exceptionMask & {16{interruptEnable}};

   priority_encoder16 u_int_enc (.in(exceptionReq), .valid(int_v), .index(int_idx));
   priority_encoder16 u_ext_enc (.in(extReq),       .valid(ext_v), .index(ext_idx));

   assign int_cause = {1'b0, int_idx};
   assign winner    = int_v ? int_cause : (CAUSE_IRQ_BASE | {1'b0, ext_idx});

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         heldCause      <= 5'd0;
         cause          <= 5'd0;
         exceptionTaken <= 1'b0;
      end else begin
         exceptionTaken <= 1'b0;
         case (state)
            IDLE: begin
               if (int_v || ext_v) begin
                  state     <= HELD;
                  heldCause <= winner;
               end
            end
            HELD: begin
               if (exceptionAck) begin
                  state          <= TAKEN;
                  cause          <= heldCause;
                  exceptionTaken <= 1'b1;
               end else if (int_v && int_cause < heldCause) begin
                  heldCause <= int_cause;
               end else if (heldCause[4] && !extReq[heldCause[3:0]]) begin
                  // External cause lost eligibility before entry: withdraw it.
                  state <= IDLE;
               end
            end
            TAKEN:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign exceptionPending = (state == HELD) | (|exceptionReq);
   assign vectorAddress    = isrBaseAddress + ({27'b0, heldCause} << VECTOR_SHIFT);

endmodule

// File: tb/tb_exception_unit.sv
// tb/tb_exception_unit.sv - directed scoreboard bench for exception_unit
module tb_exception_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] exceptionReq, irq, exceptionMask;
   logic        interruptEnable, exceptionAck;
   logic [31:0] isrBaseAddress;
   logic        exceptionPending, exceptionTaken;
   logic [4:0]  cause;
   logic [31:0] vectorAddress;

   logic [15:0] req_l, irq_l, mask_l;
   logic        ie_l, ack_l;
   logic [31:0] base_l;
   logic        pend_l, taken_l;
   logic [4:0]  cause_l;
   logic [31:0] vec_l;

   int errors = 0;
   int checks = 0;
   int expq[$];

   always #5 clk = ~clk;

   exception_unit #(.IRQ_EDGE(1), .VECTOR_SHIFT(2)) dut (
      .clk(clk), .reset(reset), .exceptionReq(exceptionReq), .irq(irq),
      .interruptEnable(interruptEnable), .exceptionMask(exceptionMask),
      .isrBaseAddress(isrBaseAddress), .exceptionAck(exceptionAck),
      .exceptionPending(exceptionPending), .cause(cause),
      .vectorAddress(vectorAddress), .exceptionTaken(exceptionTaken)
   );

   exception_unit #(.IRQ_EDGE(0), .VECTOR_SHIFT(2)) dut_lvl (
      .clk(clk), .reset(reset), .exceptionReq(req_l), .irq(irq_l),
      .interruptEnable(ie_l), .exceptionMask(mask_l),
      .isrBaseAddress(base_l), .exceptionAck(ack_l),
      .exceptionPending(pend_l), .cause(cause_l),
      .vectorAddress(vec_l), .exceptionTaken(taken_l)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ack_push(input int c);
      expq.push_back(c);
      exceptionAck = 1'b1;
      step();
      exceptionAck = 1'b0;
   endtask

   task automatic wait_taken(input string tag);
      int exp_c;
      bit seen = 0;
      for (int i = 0; i < 4 && !seen; i++) begin
         if (exceptionTaken === 1'b1) seen = 1;
         else step();
      end
      exp_c = (expq.size() > 0) ? expq.pop_front() : -1;
      chk({tag, "_taken"}, 32'(seen), 32'd1);
      if (seen) chk({tag, "_cause"}, 32'(cause), 32'(exp_c));
   endtask

   initial begin
      reset = 1'b1; exceptionReq = '0; irq = '0; interruptEnable = 1'b0;
      exceptionMask = '0; isrBaseAddress = 32'h1000; exceptionAck = 1'b0;
      req_l = '0; irq_l = '0; mask_l = '0; ie_l = 1'b0; ack_l = 1'b0; base_l = 32'h200;
      step(); step();
      reset = 1'b0;
      chk("rst_pending", 32'(exceptionPending), 0);
      chk("rst_cause", 32'(cause), 0);
      chk("rst_taken", 32'(exceptionTaken), 0);
      chk("rst_vector", vectorAddress, 32'h1000);

      // 1: syscall
      exceptionReq = 16'h0002; #1;
      chk("t1_comb_pending", 32'(exceptionPending), 1);
      step();
      exceptionReq = 16'h0000; #1;
      chk("t1_held_pending", 32'(exceptionPending), 1);
      chk("t1_vector", vectorAddress, 32'h1004);
      chk("t1_cause_pre_ack", 32'(cause), 0);
      ack_push(1);
      wait_taken("t1");
      chk("t1_taken_vector", vectorAddress, 32'h1004);
      step();
      chk("t1_idle_taken", 32'(exceptionTaken), 0);
      chk("t1_idle_pending", 32'(exceptionPending), 0);
      chk("t1_cause_kept", 32'(cause), 1);

      // 2: edge IRQ 3
      isrBaseAddress = 32'h100; interruptEnable = 1'b1; exceptionMask = 16'h0008;
      irq = 16'h0008;
      step(); step();
      chk("t2_pending", 32'(exceptionPending), 1);
      chk("t2_vector", vectorAddress, 32'h14C);
      chk("t2_irqpend_set", 32'(dut.irqPending[3]), 1);
      ack_push(19);
      wait_taken("t2");
      chk("t2_irqpend_clr", 32'(dut.irqPending[3]), 0);
      step();
      chk("t2_idle_pending", 32'(exceptionPending), 0);
      irq = 16'h0000;
      step();

      // 3: internal beats simultaneous IRQ, IRQ follows
      irq = 16'h0008; exceptionReq = 16'h0004;
      step();
      exceptionReq = 16'h0000; #1;
      chk("t3_vector_int", vectorAddress, 32'h108);
      ack_push(2);
      wait_taken("t3a");
      step(); step();
      chk("t3_irq_pending", 32'(exceptionPending), 1);
      chk("t3_vector_irq", vectorAddress, 32'h14C);
      ack_push(19);
      wait_taken("t3b");
      step();
      irq = 16'h0000;

      // 4: IRQ 5 gated by interruptEnable, then withdrawn
      interruptEnable = 1'b0; exceptionMask = 16'h0020; irq = 16'h0020;
      step(); step();
      chk("t4_gated_pending", 32'(exceptionPending), 0);
      interruptEnable = 1'b1;
      step();
      chk("t4_held_pending", 32'(exceptionPending), 1);
      chk("t4_vector", vectorAddress, 32'h154);
      interruptEnable = 1'b0;
      step();
      chk("t4_withdrawn", 32'(exceptionPending), 0);
      chk("t4_irqpend_kept", 32'(dut.irqPending[5]), 1);
      irq = 16'h0000;

      // ack outside HELD is ignored
      exceptionAck = 1'b1;
      step();
      exceptionAck = 1'b0; #1;
      chk("ack_idle_taken", 32'(exceptionTaken), 0);
      chk("ack_idle_cause", 32'(cause), 19);

      // 5: vector wrap with cause 16
      isrBaseAddress = 32'hFFFF_FFF0; interruptEnable = 1'b1; exceptionMask = 16'h0001;
      irq = 16'h0001;
      step(); step();
      chk("t5_wrap_vector", vectorAddress, 32'h0000_0030);
      ack_push(16);
      wait_taken("t5");
      step();
      irq = 16'h0000; isrBaseAddress = 32'h100;

      // 5b: level-sensitive IRQ drops while HELD
      ie_l = 1'b1; mask_l = 16'h0004; irq_l = 16'h0004;
      step();
      chk("t5b_pending", 32'(pend_l), 1);
      chk("t5b_vector", vec_l, 32'h248);
      irq_l = 16'h0000; #1;
      chk("t5b_still_held", 32'(pend_l), 1);
      step();
      chk("t5b_dropped", 32'(pend_l), 0);
      chk("t5b_no_taken", 32'(taken_l), 0);

      // internal replaces held internal of lower priority
      exceptionReq = 16'h0004;
      step();
      exceptionReq = 16'h0001;
      step();
      exceptionReq = 16'h0000; #1;
      chk("repl_vector", vectorAddress, 32'h100);
      ack_push(0);
      wait_taken("repl");
      step();

      // 6: reset while HELD
      exceptionReq = 16'h0002;
      step();
      exceptionReq = 16'h0000; #1;
      chk("t6_held", 32'(exceptionPending), 1);
      reset = 1'b1;
      step();
      reset = 1'b0; #1;
      chk("t6_pending", 32'(exceptionPending), 0);
      chk("t6_cause", 32'(cause), 0);
      chk("t6_taken", 32'(exceptionTaken), 0);
      chk("t6_irqpend", 32'(dut.irqPending), 0);
      step();
      chk("t6_taken_next", 32'(exceptionTaken), 0);
      chk("t6_idle", 32'(exceptionPending), 0);

      chk("scoreboard_empty", 32'(expq.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
